// File: rtl/pll_pkg.sv
// Shared types and constants for the sampled PFD / charge-pump model.
package pll_pkg;

    // Tri-state PFD states plus the reset-pulse state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2,
        RST  = 2'd3
    } pfd_state_t;

    // Charge-pump current while the block is held in reset (leakage is not applied).
    localparam real SI_IN_RESET = 0.0;

    // The cycle that enters UP or DN already counts as one cycle of pulse width.
    localparam int WCNT_ENTRY = 1;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for a sampled clock input.
// The previous-value register always loads the live input, which is also the
// reset behaviour: a level held high through reset never looks like an edge.
module edge_rise_det (
    input  logic i_clk,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Track the previous sample; reset and normal operation both load the input.
    always_ff @(posedge i_clk) begin
        r_prev <= i_sig;
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/pfd_cp_sampled.sv
// Clocked phase-frequency detector with charge-pump current output.
// Samples ref/fb on i_clk, runs an IDLE/UP/DN/RST state machine with a
// programmable reset pulse, reports the signed phase error in clk cycles and
// drives the charge-pump current seen by the loop filter.
// Optional lock detector: define PFD_CP_LOCK_DET_EN to build it; otherwise
// o_lock is tied low.
module pfd_cp_sampled
    import pll_pkg::*;
#(
    parameter real ICP       = 20e-6,
    parameter real MISMATCH  = 1.0,
    parameter real ILEAK     = 0.0,
    parameter int  T_RST_CYC = 2,
    parameter int  CW        = 16,
    parameter int  LOCK_TOL  = 1,
    parameter int  LOCK_CNT  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ref,
    input  logic                 i_fb,
    output logic                 o_up,
    output logic                 o_dn,
    output real                  o_si,
    output logic signed [CW:0]   o_err,
    output logic                 o_lock
);

    localparam int RCW = (T_RST_CYC > 1) ? $clog2(T_RST_CYC) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(T_RST_CYC - 1);

    logic                 w_riseRef;
    logic                 w_riseFb;
    logic                 w_effRef;
    logic                 w_effFb;

    pfd_state_t           r_state;
    pfd_state_t           w_stateNext;
    logic [CW-1:0]        r_wcnt;
    logic [CW-1:0]        w_wcntNext;
    logic [RCW-1:0]       r_rstCnt;
    logic [RCW-1:0]       w_rstCntNext;
    logic                 r_pendRef;
    logic                 r_pendFb;
    logic                 w_pendRefNext;
    logic                 w_pendFbNext;
    logic signed [CW:0]   r_err;
    logic signed [CW:0]   w_errNext;
    logic                 w_enterRst;
    logic                 r_inReset;

    edge_rise_det u_refEdge (
        .i_clk  (i_clk),
        .i_sig  (i_ref),
        .o_rise (w_riseRef)
    );

    edge_rise_det u_fbEdge (
        .i_clk  (i_clk),
        .i_sig  (i_fb),
        .o_rise (w_riseFb)
    );

    // Rises caught during the reset pulse are replayed in the first IDLE cycle.
    assign w_effRef = w_riseRef | r_pendRef;
    assign w_effFb  = w_riseFb  | r_pendFb;

    // Next-state, width counter, pending flags and the error captured on RST entry.
    always_comb begin
        w_stateNext   = r_state;
        w_wcntNext    = r_wcnt;
        w_rstCntNext  = r_rstCnt;
        w_pendRefNext = r_pendRef;
        w_pendFbNext  = r_pendFb;
        w_errNext     = '0;
        w_enterRst    = 1'b0;
        case (r_state)
            IDLE: begin
                w_pendRefNext = 1'b0;
                w_pendFbNext  = 1'b0;
                if (w_effRef && w_effFb) begin
                    w_stateNext = RST;
                    w_enterRst  = 1'b1;
                    w_errNext   = '0;
                end else if (w_effRef) begin
                    w_stateNext = UP;
                    w_wcntNext  = CW'(WCNT_ENTRY);
                end else if (w_effFb) begin
                    w_stateNext = DN;
                    w_wcntNext  = CW'(WCNT_ENTRY);
                end
            end
            UP: begin
                if (w_riseFb) begin
                    w_stateNext = RST;
                    w_enterRst  = 1'b1;
                    w_errNext   = $signed({1'b0, r_wcnt});
                end else if (r_wcnt != '1) begin
                    w_wcntNext = r_wcnt + CW'(1);
                end
            end
            DN: begin
                if (w_riseRef) begin
                    w_stateNext = RST;
                    w_enterRst  = 1'b1;
                    w_errNext   = -$signed({1'b0, r_wcnt});
                end else if (r_wcnt != '1) begin
                    w_wcntNext = r_wcnt + CW'(1);
                end
            end
            RST: begin
                w_pendRefNext = r_pendRef | w_riseRef;
                w_pendFbNext  = r_pendFb  | w_riseFb;
                if (r_rstCnt == RST_LAST) begin
                    w_stateNext = IDLE;
                end else begin
                    w_rstCntNext = r_rstCnt + RCW'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE and clears every measurement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_rstCnt  <= '0;
            r_pendRef <= 1'b0;
            r_pendFb  <= 1'b0;
            r_err     <= '0;
            r_inReset <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_wcnt    <= w_wcntNext;
            r_rstCnt  <= w_enterRst ? '0 : w_rstCntNext;
            r_pendRef <= w_pendRefNext;
            r_pendFb  <= w_pendFbNext;
            r_inReset <= 1'b0;
            if (w_enterRst) begin
                r_err <= w_errNext;
            end
        end
    end

    assign o_up  = (r_state == UP) || (r_state == RST);
    assign o_dn  = (r_state == DN) || (r_state == RST);
    assign o_err = r_err;

    // Leakage only flows once the block is out of reset.
    assign o_si = r_inReset ? SI_IN_RESET
                            : ((o_up ? ICP : 0.0) - (o_dn ? ICP * MISMATCH : 0.0) + ILEAK);

`ifdef PFD_CP_LOCK_DET_EN
    localparam int LCW = $clog2(LOCK_CNT + 1);

    logic [LCW-1:0] r_lockCnt;
    logic [CW:0]    w_errMag;
    logic           w_inTol;

    assign w_errMag = w_errNext[CW] ? $unsigned(-w_errNext) : $unsigned(w_errNext);
    assign w_inTol  = (int'(w_errMag) <= LOCK_TOL);

    // Count consecutive in-tolerance measurements; any outlier restarts the run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lockCnt <= '0;
        end else if (w_enterRst) begin
            if (!w_inTol) begin
                r_lockCnt <= '0;
            end else if (r_lockCnt != LCW'(LOCK_CNT)) begin
                r_lockCnt <= r_lockCnt + LCW'(1);
            end
        end
    end

    assign o_lock = (r_lockCnt == LCW'(LOCK_CNT));
`else
    localparam int UNUSED_LOCK_CFG = LOCK_TOL + LOCK_CNT;

    assign o_lock = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_cp_sampled.sv
// Self-checking bench for pfd_cp_sampled: directed PFD scenarios followed by
// randomized ref/fb waveforms, compared every cycle against an event-level
// reference model that works in absolute cycle numbers and nanoamps.
module tb_pfd_cp_sampled;

    localparam int     CW        = 4;
    localparam int     T_RST     = 2;
    localparam int     LOCK_TOL  = 1;
    localparam int     LOCK_CNT  = 4;
    localparam longint UP_NA     = 20000;
    localparam longint DN_NA     = 18000;
    localparam longint LEAK_NA   = 100;
    localparam longint WIDTH_MAX = (64'd1 << CW) - 1;

    logic               clock = 1'b0;
    logic               reset;
    logic               refClk;
    logic               fbClk;
    logic               up;
    logic               dn;
    real                si;
    logic signed [CW:0] err;
    logic               lock;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: pulses are described by their start cycle and
    // the cycle at which the reset pulse ends, not by counters.
    longint cycle      = 0;
    bit     mPrevRef   = 1'b0;
    bit     mPrevFb    = 1'b0;
    int     mSide      = 0;
    longint mStart     = 0;
    bit     mInPulse   = 1'b0;
    longint mPulseEnd  = 0;
    bit     mPendRef   = 1'b0;
    bit     mPendFb    = 1'b0;
    longint mErr       = 0;
    int     mLockRun   = 0;
    bit     mInReset   = 1'b0;

    pfd_cp_sampled #(
        .ICP       (20e-6),
        .MISMATCH  (0.9),
        .ILEAK     (1e-7),
        .T_RST_CYC (T_RST),
        .CW        (CW),
        .LOCK_TOL  (LOCK_TOL),
        .LOCK_CNT  (LOCK_CNT)
    ) dut (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_ref  (refClk),
        .i_fb   (fbClk),
        .o_up   (up),
        .o_dn   (dn),
        .o_si   (si),
        .o_err  (err),
        .o_lock (lock)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
        end
    endtask

    function automatic longint minL(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic longint absL(input longint a);
        return (a < 0) ? -a : a;
    endfunction

    // A phase comparison finished: record it, start the reset pulse, update lock run.
    task automatic closeMeasurement(input longint e);
        mErr      = e;
        mSide     = 0;
        mInPulse  = 1'b1;
        mPulseEnd = cycle + T_RST;
        if (absL(e) <= LOCK_TOL) begin
            mLockRun = int'(minL(longint'(mLockRun) + 1, LOCK_CNT));
        end else begin
            mLockRun = 0;
        end
    endtask

    // Advance the model by one active clock edge with the sampled inputs.
    task automatic modelStep(input bit r, input bit f, input bit rs);
        bit riseR;
        bit riseF;
        bit effR;
        bit effF;
        riseR    = r && !mPrevRef;
        riseF    = f && !mPrevFb;
        mPrevRef = r;
        mPrevFb  = f;
        cycle++;
        if (rs) begin
            mSide    = 0;
            mInPulse = 1'b0;
            mPendRef = 1'b0;
            mPendFb  = 1'b0;
            mErr     = 0;
            mLockRun = 0;
            mInReset = 1'b1;
            return;
        end
        mInReset = 1'b0;
        if (mInPulse) begin
            mPendRef = mPendRef | riseR;
            mPendFb  = mPendFb | riseF;
            if (cycle >= mPulseEnd) mInPulse = 1'b0;
        end else if (mSide == 0) begin
            effR     = riseR || mPendRef;
            effF     = riseF || mPendFb;
            mPendRef = 1'b0;
            mPendFb  = 1'b0;
            if (effR && effF) begin
                closeMeasurement(0);
            end else if (effR) begin
                mSide  = 1;
                mStart = cycle;
            end else if (effF) begin
                mSide  = -1;
                mStart = cycle;
            end
        end else if (mSide == 1 && riseF) begin
            closeMeasurement(minL(cycle - mStart, WIDTH_MAX));
        end else if (mSide == -1 && riseR) begin
            closeMeasurement(-minL(cycle - mStart, WIDTH_MAX));
        end
    endtask

    // One clock cycle: drive on the falling edge, step model at the rising edge, check just after.
    task automatic applyStimulus(input bit r, input bit f, input bit rs);
        longint expUp;
        longint expDn;
        longint expSi;
        longint expLock;
        longint siNa;
        @(negedge clock);
        refClk = r;
        fbClk  = f;
        reset  = rs;
        @(posedge clock);
        modelStep(r, f, rs);
        #1;
        expUp = (mSide == 1 || mInPulse) ? 1 : 0;
        expDn = (mSide == -1 || mInPulse) ? 1 : 0;
        expSi = mInReset ? 0 : (expUp * UP_NA - expDn * DN_NA + LEAK_NA);
`ifdef PFD_CP_LOCK_DET_EN
        expLock = (mLockRun == LOCK_CNT) ? 1 : 0;
`else
        expLock = 0;
`endif
        siNa = longint'($rtoi(si * 1e9 + ((si >= 0.0) ? 0.5 : -0.5)));
        checkOutput("up", longint'(up), expUp);
        checkOutput("dn", longint'(dn), expDn);
        checkOutput("si_nA", siNa, expSi);
        checkOutput("err", longint'(err), mErr);
        checkOutput("lock", longint'(lock), expLock);
    endtask

    task automatic applyRepeat(input bit r, input bit f, input bit rs, input int n);
        for (int k = 0; k < n; k++) applyStimulus(r, f, rs);
    endtask

    initial begin
        int refPer;
        int fbPer;
        int refPh;
        int fbPh;
        bit rv;
        bit fv;
        bit rsv;

        reset  = 1'b1;
        refClk = 1'b0;
        fbClk  = 1'b0;

        applyRepeat(0, 0, 1, 3);
        applyRepeat(0, 0, 0, 3);

        $display("[TB] ref leads fb by 5");
        applyRepeat(1, 0, 0, 5);
        applyRepeat(1, 1, 0, 3);
        applyRepeat(0, 0, 0, 4);

        $display("[TB] fb leads ref by 3");
        applyRepeat(0, 1, 0, 3);
        applyRepeat(1, 1, 0, 3);
        applyRepeat(0, 0, 0, 4);

        $display("[TB] aligned periods");
        for (int p = 0; p < 5; p++) begin
            applyRepeat(1, 1, 0, 3);
            applyRepeat(0, 0, 0, 4);
        end

        $display("[TB] ref leads by 3 after aligned run");
        applyRepeat(1, 0, 0, 3);
        applyRepeat(1, 1, 0, 3);
        applyRepeat(0, 0, 0, 4);

        $display("[TB] fb rise during reset pulse");
        applyRepeat(1, 0, 0, 2);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        applyRepeat(0, 1, 0, 4);
        applyRepeat(1, 1, 0, 3);
        applyRepeat(0, 0, 0, 4);

        $display("[TB] reset mid-UP with ref held high");
        applyRepeat(1, 0, 0, 3);
        applyRepeat(1, 0, 1, 2);
        applyRepeat(1, 0, 0, 3);
        applyRepeat(0, 0, 0, 2);
        applyRepeat(1, 0, 0, 2);
        applyRepeat(1, 1, 0, 3);
        applyRepeat(0, 0, 0, 4);

        $display("[TB] width saturation");
        applyRepeat(1, 0, 0, 20);
        applyRepeat(1, 1, 0, 3);
        applyRepeat(0, 0, 0, 2);
        applyRepeat(0, 1, 0, 18);
        applyRepeat(1, 1, 0, 3);
        applyRepeat(0, 0, 0, 4);

        $display("[TB] randomized waveforms");
        refPer = 10;
        fbPer  = 10;
        refPh  = 0;
        fbPh   = 4;
        for (int i = 0; i < 3000; i++) begin
            rv  = (refPh < refPer / 2);
            fv  = (fbPh < fbPer / 2);
            rsv = ($urandom_range(0, 399) == 0);
            applyStimulus(rv, fv, rsv);
            refPh++;
            if (refPh >= refPer) begin
                refPh  = 0;
                refPer = int'($urandom_range(4, 24));
            end
            fbPh++;
            if (fbPh >= fbPer) begin
                fbPh  = 0;
                fbPer = ($urandom_range(0, 1) == 1) ? refPer : int'($urandom_range(2, 26));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
